// File: rtl/uart_tx_if.sv
// Host-side bundle for uart_tx: the send request, the payload, the frame
// configuration, far-end flow control, and the serial line with its status.
//   master : host / testbench side (drives the request, config and cts_n)
//   slave  : transmitter side (drives tx, tx_busy and tx_done)
interface uart_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic [1:0]        data_bit_num;
   logic              stop_bit_num;
   logic              parity_en;
   logic              parity_type;
   logic              cts_n;
   logic              tx;
   logic              tx_busy;
   logic              tx_done;

   modport master (
      output tx_start, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, cts_n,
      input  tx, tx_busy, tx_done
   );

   modport slave (
      input  tx_start, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type, cts_n,
      output tx, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter. Serialises one byte per frame: start bit, 5..8 data bits
// (LSB first), optional even/odd parity, 1 or 2 stop bits. Each bit lasts
// OVERSAMPLE baud ticks. A new frame is only accepted while cts_n is low.
// Ports:
//   clk   system clock, posedge
//   rst   asynchronous active-high reset
//   tick  baud tick, one-clk pulse, OVERSAMPLE per bit
//   bus   uart_tx_if.slave: tx_start/tx_data/config/cts_n in; tx/tx_busy/tx_done out
module uart_tx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_W     = 8
) (
   input logic     clk,
   input logic     rst,
   input logic     tick,
   uart_tx_if.slave bus
);

   localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int unsigned IdxW = (DATA_W > 8) ? $clog2(DATA_W) : 3;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

   state_t            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              stop_second_q, stop_second_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        nbits_q, nbits_d;
   logic              stop2_q, stop2_d;
   logic              par_en_q, par_en_d;
   logic              par_odd_q, par_odd_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;

   logic              bit_end;
   logic [IdxW-1:0]   last_idx;
   logic              par_bit;

   // Even parity over the N configured data bits only; bits above N-1 are ignored.
   always_comb begin
      par_bit = 1'b0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (i < int'(nbits_q) + 5) par_bit = par_bit ^ data_q[i];
      end
   end

   assign bit_end  = tick && (cnt_q == CntW'(OVERSAMPLE - 1));
   assign last_idx = IdxW'(nbits_q) + IdxW'(4);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      stop_second_d = stop_second_q;
      data_d        = data_q;
      nbits_d       = nbits_q;
      stop2_d       = stop2_q;
      par_en_d      = par_en_q;
      par_odd_d     = par_odd_q;
      done_d        = 1'b0;

      if (state_q == StIdle) begin
         if (bus.tx_start && !bus.cts_n) begin
            state_d       = StStart;
            cnt_d         = '0;
            idx_d         = '0;
            stop_second_d = 1'b0;
            data_d        = bus.tx_data;
            nbits_d       = bus.data_bit_num;
            stop2_d       = bus.stop_bit_num;
            par_en_d      = bus.parity_en;
            par_odd_d     = bus.parity_type;
         end
      end else begin
         if (tick) cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
         if (bit_end) begin
            case (state_q)
               StStart: begin
                  state_d = StData;
                  idx_d   = '0;
               end
               StData: begin
                  if (idx_q == last_idx) state_d = par_en_q ? StParity : StStop;
                  else                   idx_d   = idx_q + IdxW'(1);
               end
               StParity: state_d = StStop;
               StStop: begin
                  // Two stop bits: run the STOP state twice.
                  if (stop2_q && !stop_second_q) begin
                     stop_second_d = 1'b1;
                  end else begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end

      // Line level follows the next state so tx changes on the same edge as the FSM.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = data_d[idx_d];
         StParity: tx_d = par_bit ^ par_odd_q;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         idx_q         <= '0;
         stop_second_q <= 1'b0;
         data_q        <= '0;
         nbits_q       <= '0;
         stop2_q       <= 1'b0;
         par_en_q      <= 1'b0;
         par_odd_q     <= 1'b0;
         tx_q          <= 1'b1;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         stop_second_q <= stop_second_d;
         data_q        <= data_d;
         nbits_q       <= nbits_d;
         stop2_q       <= stop2_d;
         par_en_q      <= par_en_d;
         par_odd_q     <= par_odd_d;
         tx_q          <= tx_d;
         done_q        <= done_d;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = (state_q != StIdle);
   assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (OVERSAMPLE=16, DATA_W=8).
module tb_uart_tx;

   localparam int OS = 16;

   logic clk;
   logic rst;
   logic tick;
   bit   tick_rand;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int busy_ticks = 0;

   logic exp_q[$];

   uart_tx_if #(.DATA_W(8)) bus ();

   uart_tx #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Baud tick: alternating, or random (possibly several consecutive clks high).
   initial begin
      tick = 1'b0;
      forever begin
         @(negedge clk);
         if (tick_rand) tick = ($urandom_range(0, 1) == 1);
         else           tick = ~tick;
      end
   end

   always @(posedge clk) begin
      if (bus.tx_done) done_cnt <= done_cnt + 1;
      if (tick && bus.tx_busy) busy_ticks <= busy_ticks + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n;) begin
         @(posedge clk);
         if (tick) i++;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] nb, input logic sb,
                             input logic pe, input logic pt, input string name);
      int   n, nexp, edges, d0, b0, exp_len;
      bit   seen;
      logic p, e;
      @(negedge clk);
      n = int'(nb) + 5;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
      if (pe) begin
         p = pt;
         for (int i = 0; i < n; i++) p = p ^ d[i];
         exp_q.push_back(p);
      end
      exp_q.push_back(1'b1);
      if (sb) exp_q.push_back(1'b1);
      nexp    = exp_q.size();
      exp_len = OS * (2 + n + int'(pe) + int'(sb));
      d0 = done_cnt;
      b0 = busy_ticks;
      bus.tx_data      = d;
      bus.data_bit_num = nb;
      bus.stop_bit_num = sb;
      bus.parity_en    = pe;
      bus.parity_type  = pt;
      bus.cts_n        = 1'b0;
      bus.tx_start     = 1'b1;
      edges = 0;
      seen  = 0;
      while (!seen && edges < 1000) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.tx_busy) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s accept: tx_busy never rose within 1000 clks", name);
         bus.tx_start = 1'b0;
         return;
      end
      if (edges !== 1) begin
         failures++;
         $display("FAIL %s accept latency: %0d clks, expected 1", name, edges);
      end
      bus.tx_start = 1'b0;
      for (int k = 0; k < nexp; k++) begin
         wait_ticks(OS / 2);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (bus.tx !== e) begin
            failures++;
            $display("FAIL %s bit %0d: tx=%0b expected %0b", name, k, bus.tx, e);
         end
         // Mid-frame: scrambled config and a stray request must have no effect.
         if (k == 1) begin
            bus.tx_start     = 1'b1;
            bus.tx_data      = ~d;
            bus.data_bit_num = ~nb;
            bus.stop_bit_num = ~sb;
            bus.parity_en    = ~pe;
            bus.parity_type  = ~pt;
         end
         if (k == 3) bus.tx_start = 1'b0;
         wait_ticks(OS - OS / 2);
      end
      #1;
      checks++;
      if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) begin
         failures++;
         $display("FAIL %s end: done=%0b busy=%0b tx=%0b expected 1 0 1", name, bus.tx_done,
                  bus.tx_busy, bus.tx);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.tx_done !== 1'b0 || (done_cnt - d0) !== 1) begin
         failures++;
         $display("FAIL %s done pulse: done=%0b pulses=%0d expected 0 and 1", name, bus.tx_done,
                  done_cnt - d0);
      end
      checks++;
      if ((busy_ticks - b0) !== exp_len) begin
         failures++;
         $display("FAIL %s busy ticks: %0d expected %0d", name, busy_ticks - b0, exp_len);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.tx !== 1'b1) begin
         failures++;
         $display("FAIL reset tx: %0b expected 1", bus.tx);
      end
      checks++;
      if (bus.tx_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset tx_busy: %0b expected 0", bus.tx_busy);
      end
      checks++;
      if (bus.tx_done !== 1'b0) begin
         failures++;
         $display("FAIL reset tx_done: %0b expected 0", bus.tx_done);
      end
      rst = 1'b0;
   endtask

   task automatic test_frames();
      send_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, "8N1_A5");
      send_frame(8'h55, 2'd2, 1'b0, 1'b1, 1'b0, "7E1_55");
      send_frame(8'h2A, 2'd1, 1'b1, 1'b1, 1'b1, "6O2_2A");
      tick_rand = 1'b1;
      send_frame(8'hFB, 2'd0, 1'b1, 1'b0, 1'b0, "5N2_1B_hi_bits_set");
      tick_rand = 1'b0;
   endtask

   task automatic test_cts();
      int bad;
      @(negedge clk);
      bus.cts_n    = 1'b1;
      bus.tx_start = 1'b1;
      bus.tx_data  = 8'h96;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         wait_ticks(1);
         #1;
         if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL cts hold: %0d ticks with activity, expected 0", bad);
      end
      send_frame(8'h96, 2'd3, 1'b0, 1'b1, 1'b1, "cts_release_8O1");
   endtask

   task automatic test_reset_mid_frame();
      int  d0, bad, edges;
      bit  seen;
      @(negedge clk);
      d0 = done_cnt;
      bus.tx_data      = 8'hFF;
      bus.data_bit_num = 2'd3;
      bus.stop_bit_num = 1'b0;
      bus.parity_en    = 1'b1;
      bus.parity_type  = 1'b0;
      bus.cts_n        = 1'b0;
      bus.tx_start     = 1'b1;
      seen  = 0;
      edges = 0;
      while (!seen && edges < 1000) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.tx_busy) seen = 1;
      end
      bus.tx_start = 1'b0;
      wait_ticks(OS * 4);
      #2;
      checks++;
      if (!seen || bus.tx !== 1'b1) begin
         failures++;
         $display("FAIL mid-frame reset precondition: busy_seen=%0b tx=%0b expected 1 1", seen,
                  bus.tx);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
         failures++;
         $display("FAIL mid-frame reset immediate: tx=%0b busy=%0b expected 1 0", bus.tx,
                  bus.tx_busy);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         wait_ticks(1);
         #1;
         if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL no resume after reset: %0d active ticks, expected 0", bad);
      end
      checks++;
      if ((done_cnt - d0) !== 0) begin
         failures++;
         $display("FAIL no tx_done on reset: %0d pulses, expected 0", done_cnt - d0);
      end
      send_frame(8'h00, 2'd3, 1'b0, 1'b1, 1'b0, "8E1_00_after_reset");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h3C, 2'd3, 1'b0, 1'b1, 1'b1, "b2b_8O1_3C");
      send_frame(8'hC3, 2'd2, 1'b1, 1'b0, 1'b0, "b2b_7N2_C3");
   endtask

   initial begin
      tick_rand        = 1'b0;
      rst              = 1'b1;
      bus.tx_start     = 1'b0;
      bus.tx_data      = '0;
      bus.data_bit_num = 2'd3;
      bus.stop_bit_num = 1'b0;
      bus.parity_en    = 1'b0;
      bus.parity_type  = 1'b0;
      bus.cts_n        = 1'b0;
      test_reset();
      test_frames();
      test_cts();
      test_reset_mid_frame();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
